pedestrian_request: RTL and testbench

PEDESTRIAN_REQUEST -- requirements
Module: pedestrian_request

---
 rtl/pedestrian_request.sv | 118 +++++++++++
 tb/tb_pedestrian_request.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pedestrian_request.sv
// Debounces a pedestrian push-button and raises a request (bt pulse + pending level) for the light controller.
// Optional two-flop input synchronizer enabled by defining PEDESTRIAN_REQUEST_SYNC_EN.
module pedestrian_request #(
   parameter logic [7:0] DEBOUNCE_CYCLES = 8'd3,
   parameter logic [7:0] HOLDOFF_CYCLES  = 8'd4
) (
   input  logic clk,
   input  logic rst,
   input  logic bt_raw,
   input  logic ack,
   output logic bt,
   output logic pending
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, HOLDOFF} state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       bt_q, bt_d;
   logic       pending_q, pending_d;
   logic       accept;
   logic       s;

`ifdef PEDESTRIAN_REQUEST_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= bt_raw;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   assign s = bt_raw;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (s) begin
               if (DEBOUNCE_CYCLES == 8'd1) begin
                  accept  = 1'b1;
                  state_d = PRESSED;
                  cnt_d   = 8'd0;
               end else begin
                  state_d = DEBOUNCE;
                  cnt_d   = 8'd1;
               end
            end
         end
         DEBOUNCE: begin
            if (!s) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else if (cnt_q == DEBOUNCE_CYCLES - 8'd1) begin
               accept  = 1'b1;
               state_d = PRESSED;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         PRESSED: begin
            // cnt here tracks the run of released samples
            if (s) begin
               cnt_d = 8'd0;
            end else if (cnt_q == DEBOUNCE_CYCLES - 8'd1) begin
               cnt_d   = 8'd0;
               state_d = (HOLDOFF_CYCLES == 8'd0) ? IDLE : HOLDOFF;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HOLDOFF: begin
            if (cnt_q == HOLDOFF_CYCLES - 8'd1) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase

      // A press landing with ack is a fresh request: the old one was just served.
      bt_d      = accept & (~pending_q | ack);
      pending_d = accept ? 1'b1 : (ack ? 1'b0 : pending_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         bt_q      <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bt_q      <= bt_d;
         pending_q <= pending_d;
      end
   end

   assign bt      = bt_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_pedestrian_request.sv
// Bench for pedestrian_request: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a run-length model of the button rules.
module tb_pedestrian_request;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bt_raw = 1'b0;
   logic ack = 1'b0;
   logic bt0, pend0, bt1, pend1;

   int n_chk = 0;
   int n_fail = 0;

`ifdef PEDESTRIAN_REQUEST_SYNC_EN
   localparam int ACC = 4;
`else
   localparam int ACC = 2;
`endif

   always #5 clk = ~clk;

   pedestrian_request u0 (
      .clk(clk), .rst(rst), .bt_raw(bt_raw), .ack(ack), .bt(bt0), .pending(pend0)
   );

   pedestrian_request #(.DEBOUNCE_CYCLES(8'd1), .HOLDOFF_CYCLES(8'd0)) u1 (
      .clk(clk), .rst(rst), .bt_raw(bt_raw), .ack(ack), .bt(bt1), .pending(pend1)
   );

   task automatic chk(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: mode 0 = waiting for a press, 1 = button held, 2 = holdoff.
   int   mode[2]  = '{0, 0};
   int   ones[2]  = '{0, 0};
   int   zeros[2] = '{0, 0};
   int   hold[2]  = '{0, 0};
   logic ebt[2]   = '{1'b0, 1'b0};
   logic epd[2]   = '{1'b0, 1'b0};
   logic sq1 = 1'b0, sq2 = 1'b0, ms;

   task automatic step(input int k, input int d, input int h, input logic sv);
      logic acc;
      acc = 1'b0;
      if (mode[k] == 0) begin
         ones[k] = sv ? ones[k] + 1 : 0;
         if (ones[k] == d) begin
            acc      = 1'b1;
            mode[k]  = 1;
            zeros[k] = 0;
         end
      end else if (mode[k] == 1) begin
         zeros[k] = sv ? 0 : zeros[k] + 1;
         if (zeros[k] == d) begin
            ones[k] = 0;
            hold[k] = h;
            mode[k] = (h == 0) ? 0 : 2;
         end
      end else begin
         hold[k]--;
         if (hold[k] == 0) begin
            mode[k] = 0;
            ones[k] = 0;
         end
      end
      ebt[k] = acc && (!epd[k] || ack);
      if (acc) epd[k] = 1'b1;
      else if (ack) epd[k] = 1'b0;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            mode[k] = 0; ones[k] = 0; zeros[k] = 0; hold[k] = 0;
            ebt[k] = 1'b0; epd[k] = 1'b0;
         end
         sq1 = 1'b0;
         sq2 = 1'b0;
      end else begin
`ifdef PEDESTRIAN_REQUEST_SYNC_EN
         ms  = sq2;
         sq2 = sq1;
         sq1 = bt_raw;
`else
         ms  = bt_raw;
`endif
         step(0, 3, 4, ms);
         step(1, 1, 0, ms);
      end
   end

   always @(negedge clk) begin
      chk("u0_bt", bt0, ebt[0]);
      chk("u0_pending", pend0, epd[0]);
      chk("u1_bt", bt1, ebt[1]);
      chk("u1_pending", pend1, epd[1]);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      repeat (2) tick();
      rst = 1'b0;

      // reset quiet period
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("quiet_bt", bt0, 1'b0);
         chk("quiet_pending", pend0, 1'b0);
      end

      // one-cycle glitch
      bt_raw = 1'b1;
      tick();
      bt_raw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("glitch_bt", bt0, 1'b0);
      end

      // valid press held 8 cycles
      bt_raw = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         chk("press_bt", bt0, e == ACC);
         chk("press_pending", pend0, e >= ACC);
      end
      bt_raw = 1'b0;

      // re-press during holdoff and a later press while still pending
      repeat (5) tick();
      bt_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("holdoff_bt", bt0, 1'b0);
      end
      bt_raw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("holdoff_bt", bt0, 1'b0);
      end
      bt_raw = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("dup_bt", bt0, 1'b0);
         chk("dup_pending", pend0, 1'b1);
      end
      bt_raw = 1'b0;
      repeat (12) tick();

      // lone ack clears
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("ack_clear", pend0, 1'b0);

      // ack on the acceptance edge: set wins
      bt_raw = 1'b1;
      for (int e = 0; e <= ACC + 1; e++) begin
         ack = (e == ACC);
         tick();
         chk("race_bt", bt0, e == ACC);
         chk("race_pending", pend0, e >= ACC);
      end
      ack = 1'b0;
      bt_raw = 1'b0;
      repeat (12) tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("ack_after_race", pend0, 1'b0);
      repeat (2) tick();

      // reset mid-debounce, then a fresh full debounce with the button still held
      bt_raw = 1'b1;
      repeat (3) tick();
      #2 rst = 1'b1;
      #1 chk("rst_async_bt", bt0, 1'b0);
      chk("rst_async_pending", pend0, 1'b0);
      tick();
      #2 rst = 1'b0;
      for (int e = 0; e <= ACC + 2; e++) begin
         tick();
         chk("post_rst_bt", bt0, e == ACC);
      end
      bt_raw = 1'b0;

      // randomized run, checked by the model every cycle
      for (int i = 0; i < 4000; i++) begin
         tick();
         if ($urandom_range(4, 0) == 0) bt_raw = ~bt_raw;
         ack = ($urandom_range(7, 0) == 0);
         if ($urandom_range(399, 0) == 0) begin
            #2 rst = 1'b1;
            tick();
            #2 rst = 1'b0;
         end
      end

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
